cv_pad_mux: RTL and testbench

Parametrised ColecoVision controller-port generator for `NUM_PADS` pads. It sits between the hps_io joystick words and `cv_console`. It turns each 20-bit joystick word into the registered port signals p1–p4, p6, p7 and p9, and supports:
- keypad/joystick select scanning;
- pad swap;
- per-button autofire;
- a quadrature roller-controller (spinner) emulator driving p7/p9.

---
 rtl/cv_pad_mux.sv | 251 +++++++++++++++++++++++++
 tb/tb_cv_pad_mux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_pad_mux.sv
// ColecoVision controller-port generator: keypad/joystick scan, pad swap, autofire, quadrature spinner.
// Outputs registered on ce (one tick latency); optional autofire gating via `CV_PAD_AUTOFIRE_EN.
module cv_pad_mux #(
   parameter int NUM_PADS = 2,
   parameter int AF_DIV   = 178957,
   parameter int SPIN_W   = 8,
   parameter int SPIN_DIV = 1024
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       ce,
   input  logic [20*NUM_PADS-1:0]     joy_i,
   input  logic                       swap_i,
   input  logic [2*NUM_PADS-1:0]      af_en_i,
   input  logic [NUM_PADS-1:0]        spin_en_i,
   input  logic [SPIN_W*NUM_PADS-1:0] spin_d_i,
   input  logic [NUM_PADS-1:0]        spin_stb_i,
   input  logic [NUM_PADS-1:0]        sel_kp_n_i,
   input  logic [NUM_PADS-1:0]        sel_js_n_i,
   output logic [4*NUM_PADS-1:0]      p1234_o,
   output logic [NUM_PADS-1:0]        p6_o,
   output logic [NUM_PADS-1:0]        p7_o,
   output logic [NUM_PADS-1:0]        p9_o
);

   localparam int AW    = SPIN_W + 2;
   localparam int XW    = SPIN_W + 4;
   localparam int SC_W  = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SPIN_DIV - 1);
   localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (AW - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX;

   function automatic logic [AW-1:0] sat(input logic signed [XW-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[AW-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[AW-1:0];
      end
      return v[AW-1:0];
   endfunction

   function automatic logic [3:0] kp_code(input logic [19:0] j);
      if      (j[8])  return 4'b0011;
      else if (j[9])  return 4'b1110;
      else if (j[10]) return 4'b1101;
      else if (j[11]) return 4'b0110;
      else if (j[12]) return 4'b0001;
      else if (j[13]) return 4'b1001;
      else if (j[14]) return 4'b0111;
      else if (j[15]) return 4'b1100;
      else if (j[16]) return 4'b1000;
      else if (j[17]) return 4'b1011;
      else if (j[6])  return 4'b1010;
      else if (j[7])  return 4'b0101;
      else if (j[18]) return 4'b0100;
      else if (j[19]) return 4'b0010;
      return 4'b1111;
   endfunction

   function automatic logic [1:0] quad_fwd(input logic [1:0] s);
      case (s)
         2'b11:   return 2'b10;
         2'b10:   return 2'b00;
         2'b00:   return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   function automatic logic [1:0] quad_rev(input logic [1:0] s);
      case (s)
         2'b11:   return 2'b01;
         2'b01:   return 2'b00;
         2'b00:   return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   // Shared step timebase for all spinners.
   logic [SC_W-1:0] spin_cnt_q, spin_cnt_d;
   logic            spin_tick;

   always_comb begin
      spin_cnt_d = spin_cnt_q;
      spin_tick  = 1'b0;
      if (ce) begin
         if (spin_cnt_q == SC_LAST) begin
            spin_cnt_d = '0;
            spin_tick  = 1'b1;
         end else begin
            spin_cnt_d = spin_cnt_q + SC_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         spin_cnt_q <= '0;
      end else begin
         spin_cnt_q <= spin_cnt_d;
      end
   end

`ifdef CV_PAD_AUTOFIRE_EN
   localparam int AF_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
   localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_DIV - 1);

   logic [AF_W-1:0] af_cnt_q, af_cnt_d;
   logic            af_phase_q, af_phase_d;

   always_comb begin
      af_cnt_d   = af_cnt_q;
      af_phase_d = af_phase_q;
      if (ce) begin
         if (af_cnt_q == AF_LAST) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
         end else begin
            af_cnt_d = af_cnt_q + AF_W'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         af_cnt_q   <= '0;
         af_phase_q <= 1'b1;
      end else begin
         af_cnt_q   <= af_cnt_d;
         af_phase_q <= af_phase_d;
      end
   end
`else
   logic unused_af;
   assign unused_af = ^af_en_i;
   localparam int unused_af_div = AF_DIV;
`endif

   // Swap only exchanges the joystick words; select lines stay physical.
   logic [20*NUM_PADS-1:0] joy_sw;

   for (genvar n = 0; n < NUM_PADS; n++) begin : g_swap
      if (NUM_PADS > 1 && n < 2) begin : g_xchg
         assign joy_sw[20*n +: 20] = swap_i ? joy_i[20*(1-n) +: 20] : joy_i[20*n +: 20];
      end else begin : g_pass
         assign joy_sw[20*n +: 20] = joy_i[20*n +: 20];
      end
   end

   if (NUM_PADS == 1) begin : g_noswap
      logic unused_swap;
      assign unused_swap = swap_i;
   end

   for (genvar n = 0; n < NUM_PADS; n++) begin : g_pad
      logic [19:0]              j;
      logic                     fire1, fire2;
      logic [3:0]               kp_val, js_val;
      logic                     kp_p6, js_p6;
      logic [3:0]               p1234_q, p1234_d;
      logic                     p6_q, p6_d;
      logic signed [SPIN_W-1:0] d;
      logic signed [XW-1:0]     d_x, acc_x, pend_x, step;
      logic signed [AW-1:0]     acc_q, acc_d, pend_q, pend_d;
      logic [1:0]               quad_q, quad_d;

      assign j = joy_sw[20*n +: 20];
      assign d = spin_d_i[SPIN_W*n +: SPIN_W];

`ifdef CV_PAD_AUTOFIRE_EN
      assign fire1 = j[4] & (~af_en_i[2*n]   | af_phase_q);
      assign fire2 = j[5] & (~af_en_i[2*n+1] | af_phase_q);
`else
      assign fire1 = j[4];
      assign fire2 = j[5];
`endif

      always_comb begin
         kp_val = 4'hF;
         kp_p6  = 1'b1;
         js_val = 4'hF;
         js_p6  = 1'b1;
         if (!sel_kp_n_i[n]) begin
            kp_val = kp_code(j);
            kp_p6  = ~fire2;
         end
         if (!sel_js_n_i[n]) begin
            js_val = ~j[3:0];
            js_p6  = ~fire1;
         end
         p1234_d = ce ? (kp_val & js_val) : p1234_q;
         p6_d    = ce ? (kp_p6 & js_p6) : p6_q;
      end

      // Strobes accumulate in pend between ce ticks and are merged together with any step.
      always_comb begin
         acc_d  = acc_q;
         pend_d = pend_q;
         quad_d = quad_q;
         step   = '0;
         d_x    = '0;
         if (spin_stb_i[n]) begin
            d_x = {{(XW-SPIN_W){d[SPIN_W-1]}}, d};
         end
         acc_x  = {{2{acc_q[AW-1]}}, acc_q};
         pend_x = {{2{pend_q[AW-1]}}, pend_q};
         if (!spin_en_i[n]) begin
            pend_d = '0;
            if (ce) begin
               acc_d  = '0;
               quad_d = 2'b11;
            end
         end else if (ce) begin
            if (spin_tick && acc_q != '0) begin
               if (acc_q[AW-1]) begin
                  step   = '1;
                  quad_d = quad_rev(quad_q);
               end else begin
                  step   = XW'(1);
                  quad_d = quad_fwd(quad_q);
               end
            end
            acc_d  = sat(acc_x + pend_x + d_x - step);
            pend_d = '0;
         end else begin
            pend_d = sat(pend_x + d_x);
         end
      end

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            p1234_q <= 4'hF;
            p6_q    <= 1'b1;
            acc_q   <= '0;
            pend_q  <= '0;
            quad_q  <= 2'b11;
         end else begin
            p1234_q <= p1234_d;
            p6_q    <= p6_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            quad_q  <= quad_d;
         end
      end

      assign p1234_o[4*n +: 4] = p1234_q;
      assign p6_o[n]           = p6_q;
      assign p7_o[n]           = quad_q[1];
      assign p9_o[n]           = quad_q[0];
   end

endmodule

// File: tb/tb_cv_pad_mux.sv
// Directed bench for cv_pad_mux: keypad/joystick vector table plus autofire and spinner sequences.
module tb_cv_pad_mux;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce;
   logic [39:0] joy_i;
   logic        swap_i;
   logic [3:0]  af_en_i;
   logic [1:0]  spin_en_i;
   logic [15:0] spin_d_i;
   logic [1:0]  spin_stb_i;
   logic [1:0]  sel_kp_n_i;
   logic [1:0]  sel_js_n_i;
   logic [7:0]  p1234_o;
   logic [1:0]  p6_o;
   logic [1:0]  p7_o;
   logic [1:0]  p9_o;

   int n_checks = 0;
   int n_errors = 0;

   cv_pad_mux #(
      .NUM_PADS(2),
      .AF_DIV  (4),
      .SPIN_W  (8),
      .SPIN_DIV(2)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ce        (ce),
      .joy_i     (joy_i),
      .swap_i    (swap_i),
      .af_en_i   (af_en_i),
      .spin_en_i (spin_en_i),
      .spin_d_i  (spin_d_i),
      .spin_stb_i(spin_stb_i),
      .sel_kp_n_i(sel_kp_n_i),
      .sel_js_n_i(sel_js_n_i),
      .p1234_o   (p1234_o),
      .p6_o      (p6_o),
      .p7_o      (p7_o),
      .p9_o      (p9_o)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [1:0]  kp_n;
      logic [1:0]  js_n;
      logic        swap;
      logic [19:0] j0;
      logic [19:0] j1;
      logic [7:0]  e_p1234;
      logic [1:0]  e_p6;
   } vec_t;

   vec_t vecs [10];
   logic [1:0] seq_a [10];
   logic [1:0] seq_b [12];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic tick();
      ce = 1'b1;
      @(posedge clk_sys);
      #1;
      ce = 1'b0;
   endtask

   task automatic reset_dut();
      ce    = 1'b0;
      reset = 1'b1;
      idle();
      idle();
      reset = 1'b0;
   endtask

   task automatic strobe0(input logic [7:0] d);
      spin_d_i[7:0] = d;
      spin_stb_i    = 2'b01;
      idle();
      spin_stb_i    = 2'b00;
   endtask

   initial begin
      logic [1:0]  cur, prev;
      logic [7:0]  prev_p1234;
      logic [1:0]  prev_p6;
      logic        af_exp;
      int          changes;

      //            kp_n   js_n   swp   j0         j1         p1234  p6
      vecs[0] = '{2'b10, 2'b11, 1'b0, 20'h08800, 20'h00000, 8'hF6, 2'b11};
      vecs[1] = '{2'b11, 2'b10, 1'b0, 20'h00019, 20'h00000, 8'hF6, 2'b10};
      vecs[2] = '{2'b11, 2'b11, 1'b0, 20'h00019, 20'h00000, 8'hFF, 2'b11};
      vecs[3] = '{2'b10, 2'b11, 1'b1, 20'h00000, 20'h00040, 8'hFA, 2'b11};
      vecs[4] = '{2'b10, 2'b10, 1'b0, 20'h00122, 20'h00000, 8'hF1, 2'b10};
      vecs[5] = '{2'b01, 2'b11, 1'b0, 20'h00000, 20'hC0080, 8'h5F, 2'b11};
      vecs[6] = '{2'b11, 2'b01, 1'b0, 20'h00000, 20'h00014, 8'hBF, 2'b01};
      vecs[7] = '{2'b01, 2'b11, 1'b1, 20'h20000, 20'h00000, 8'hBF, 2'b11};
      vecs[8] = '{2'b10, 2'b11, 1'b0, 20'h00020, 20'h00000, 8'hFF, 2'b10};
      vecs[9] = '{2'b10, 2'b11, 1'b0, 20'h80000, 20'h00000, 8'hF2, 2'b11};

      seq_a = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
      seq_b = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

      reset      = 1'b0;
      ce         = 1'b0;
      joy_i      = '0;
      swap_i     = 1'b0;
      af_en_i    = '0;
      spin_en_i  = '0;
      spin_d_i   = '0;
      spin_stb_i = '0;
      sel_kp_n_i = 2'b11;
      sel_js_n_i = 2'b11;

      reset_dut();
      check("reset_p1234", {8'h0, p1234_o}, 16'h00FF);
      check("reset_p6", {14'h0, p6_o}, 16'h0003);
      check("reset_p7", {14'h0, p7_o}, 16'h0003);
      check("reset_p9", {14'h0, p9_o}, 16'h0003);

      // Each vector: outputs must hold across a non-ce cycle, then update on the ce tick.
      prev_p1234 = 8'hFF;
      prev_p6    = 2'b11;
      for (int i = 0; i < 10; i++) begin
         sel_kp_n_i = vecs[i].kp_n;
         sel_js_n_i = vecs[i].js_n;
         swap_i     = vecs[i].swap;
         joy_i      = {vecs[i].j1, vecs[i].j0};
         idle();
         check($sformatf("vec%0d_hold_p1234", i), {8'h0, p1234_o}, {8'h0, prev_p1234});
         tick();
         check($sformatf("vec%0d_p1234", i), {8'h0, p1234_o}, {8'h0, vecs[i].e_p1234});
         check($sformatf("vec%0d_p6", i), {14'h0, p6_o}, {14'h0, vecs[i].e_p6});
         prev_p1234 = vecs[i].e_p1234;
         prev_p6    = vecs[i].e_p6;
      end

      // Autofire on pad 0 fire1, joystick side selected.
      joy_i      = 40'h10;
      swap_i     = 1'b0;
      af_en_i    = 4'b0001;
      sel_kp_n_i = 2'b11;
      sel_js_n_i = 2'b10;
      reset_dut();
      for (int k = 1; k <= 12; k++) begin
         tick();
`ifdef CV_PAD_AUTOFIRE_EN
         af_exp = (((k - 1) / 4) % 2) == 1;
`else
         af_exp = 1'b0;
`endif
         check($sformatf("af_tick%0d_p6", k), {15'h0, p6_o[0]}, {15'h0, af_exp});
      end
      af_en_i    = '0;
      joy_i      = '0;
      sel_js_n_i = 2'b11;

      // Spinner +3: steps on ticks 2, 4, 6 then holds.
      spin_en_i = 2'b01;
      reset_dut();
      strobe0(8'd3);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("spin3_tick%0d", k), {14'h0, p7_o[0], p9_o[0]}, {14'h0, seq_a[k-1]});
      end
      check("spin_pad1_idle", {14'h0, p7_o[1], p9_o[1]}, 16'h0003);

      // Two pending strobes plus a third strobe landing on a step tick.
      reset_dut();
      strobe0(8'd1);
      strobe0(8'd1);
      for (int k = 1; k <= 12; k++) begin
         if (k == 2) begin
            spin_d_i[7:0] = 8'd2;
            spin_stb_i    = 2'b01;
         end
         tick();
         spin_stb_i = 2'b00;
         check($sformatf("spinmerge_tick%0d", k), {14'h0, p7_o[0], p9_o[0]}, {14'h0, seq_b[k-1]});
      end

      // Saturation: six -128 strobes clamp at -511, giving exactly 511 reverse steps.
      reset_dut();
      for (int s = 0; s < 6; s++) strobe0(8'h80);
      prev    = {p7_o[0], p9_o[0]};
      changes = 0;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         cur = {p7_o[0], p9_o[0]};
         if (cur != prev) changes++;
         prev = cur;
         if (k == 2) check("sat_first_dir", {14'h0, cur}, 16'h0001);
      end
      check("sat_step_count", changes[15:0], 16'd511);
      check("sat_final_state", {14'h0, prev}, 16'h0002);

      // Spinner disable mid-sequence clears accumulator and parks at 11.
      reset_dut();
      strobe0(8'd3);
      tick();
      tick();
      check("dis_pre", {14'h0, p7_o[0], p9_o[0]}, 16'h0002);
      spin_en_i = 2'b00;
      tick();
      check("dis_forced", {14'h0, p7_o[0], p9_o[0]}, 16'h0003);
      spin_en_i = 2'b01;
      changes   = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if ({p7_o[0], p9_o[0]} != 2'b11) changes++;
      end
      check("dis_no_residual", changes[15:0], 16'd0);

      // Reset mid-sequence: immediate return to 11, no later steps.
      reset_dut();
      strobe0(8'd3);
      tick();
      tick();
      check("rst_mid_pre", {14'h0, p7_o[0], p9_o[0]}, 16'h0002);
      reset = 1'b1;
      idle();
      check("rst_mid_p7p9", {14'h0, p7_o[0], p9_o[0]}, 16'h0003);
      reset   = 1'b0;
      changes = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if ({p7_o[0], p9_o[0]} != 2'b11) changes++;
      end
      check("rst_mid_no_steps", changes[15:0], 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
